// File: rtl/serial_rx_if.sv
// serial_rx_if: bundles the serial line, frame configuration and the decoded
// word/strobe outputs of the pulse-width receiver.
// master: the side that drives the line and configuration (link / test harness).
// slave:  the receiver itself.
interface serial_rx_if;
    logic         y;
    logic         y0;
    logic [7:0]   nbits;
    logic [31:0]  n0;
    logic [31:0]  n1;
    logic [255:0] data;
    logic         valid;
    logic         err;
    logic         busy;

    modport master (
        output y, y0, nbits, n0, n1,
        input  data, valid, err, busy
    );

    modport slave (
        input  y, y0, nbits, n0, n1,
        output data, valid, err, busy
    );
endinterface

// File: rtl/serial_rx.sv
// serial_rx: pulse-width serial decoder, receive side of serial_tx.
// Each active pulse on y encodes one bit by its width (n0 clocks -> 0,
// n1 clocks -> 1). nbits pulses form a frame, first bit received lands in
// the MSB of the right-justified word. A good frame loads data and strobes
// valid; an over-long pulse or an idle gap of GAP_MAX samples strobes err.
//
// Build option SERIAL_RX_STRICT_WIDTH_EN:
//   defined   - a pulse must be exactly n0 or n1 clocks wide, anything else
//               aborts the frame at the end of that pulse.
//   undefined - nearest-width decoding, ties decode as 0.
module serial_rx #(
    parameter int GAP_MAX = 64
) (
    input  logic       clk,
    input  logic       rst,
    serial_rx_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [31:0] GAP_LIMIT = 32'(GAP_MAX);

    state_t         state_q, state_n;
    logic           y0_q, y0_n;
    logic [7:0]     nbits_q, nbits_n;
    logic [31:0]    n0_q, n0_n;
    logic [31:0]    n1_q, n1_n;
    logic [31:0]    len_q, len_n;
    logic [8:0]     bit_cnt_q, bit_cnt_n;
    logic [31:0]    gap_q, gap_n;
    logic [255:0]   shreg_q, shreg_n;
    logic [255:0]   data_q, data_n;
    logic           valid_q, valid_n;
    logic           err_q, err_n;
    logic           wait_idle_q, wait_idle_n;

    logic           line_active;
    logic           start_seen;
    logic [31:0]    len_inc;
    logic [31:0]    max_width;
    logic [32:0]    long_limit;
    logic [8:0]     frame_bits;
    logic [8:0]     bit_cnt_inc;
    logic [31:0]    gap_inc;
    logic           decoded_bit;
    logic           width_bad;
    logic [255:0]   shreg_shift;

    // Mid-frame the line is judged against the idle level latched at frame
    // start; in IDLE the live y0 decides whether a frame is starting.
    assign line_active = (bus.y != y0_q);
    assign start_seen  = (bus.y != bus.y0);

    assign len_inc     = (len_q == 32'hFFFF_FFFF) ? len_q : len_q + 32'd1;
    assign max_width   = (n0_q > n1_q) ? n0_q : n1_q;
    assign long_limit  = {max_width, 1'b0};
    assign frame_bits  = (nbits_q == 8'd0) ? 9'd256 : {1'b0, nbits_q};
    assign bit_cnt_inc = bit_cnt_q + 9'd1;
    assign gap_inc     = gap_q + 32'd1;
    assign shreg_shift = (shreg_q << 1) | {255'd0, decoded_bit};

`ifdef SERIAL_RX_STRICT_WIDTH_EN
    // Exact-width decoding: only n0 or n1 are legal pulse widths.
    assign decoded_bit = (len_q == n1_q);
    assign width_bad   = (len_q != n0_q) && (len_q != n1_q);
`else
    logic [32:0] dist0;
    logic [32:0] dist1;

    // Nearest-width decoding at 33 bits so the distances never wrap.
    assign dist0 = ({1'b0, len_q} >= {1'b0, n0_q}) ? ({1'b0, len_q} - {1'b0, n0_q})
                                                   : ({1'b0, n0_q} - {1'b0, len_q});
    assign dist1 = ({1'b0, len_q} >= {1'b0, n1_q}) ? ({1'b0, len_q} - {1'b0, n1_q})
                                                   : ({1'b0, n1_q} - {1'b0, len_q});
    assign decoded_bit = (dist1 < dist0);
    assign width_bad   = 1'b0;
`endif

    // Next-state and datapath update; strobes default low every cycle.
    always_comb begin
        state_n     = state_q;
        y0_n        = y0_q;
        nbits_n     = nbits_q;
        n0_n        = n0_q;
        n1_n        = n1_q;
        len_n       = len_q;
        bit_cnt_n   = bit_cnt_q;
        gap_n       = gap_q;
        shreg_n     = shreg_q;
        data_n      = data_q;
        valid_n     = 1'b0;
        err_n       = 1'b0;
        wait_idle_n = wait_idle_q;

        case (state_q)
            IDLE: begin
                if (wait_idle_q) begin
                    // After an over-long abort, the line has to go idle
                    // before a new frame may be recognised.
                    if (!line_active) begin
                        wait_idle_n = 1'b0;
                    end
                end else if (start_seen) begin
                    y0_n      = bus.y0;
                    nbits_n   = bus.nbits;
                    n0_n      = bus.n0;
                    n1_n      = bus.n1;
                    len_n     = 32'd1;
                    bit_cnt_n = 9'd0;
                    gap_n     = 32'd0;
                    shreg_n   = '0;
                    state_n   = PULSE;
                end
            end

            PULSE: begin
                if (line_active) begin
                    if ({1'b0, len_inc} > long_limit) begin
                        err_n       = 1'b1;
                        wait_idle_n = 1'b1;
                        state_n     = IDLE;
                    end else begin
                        len_n = len_inc;
                    end
                end else if (width_bad) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    shreg_n   = shreg_shift;
                    bit_cnt_n = bit_cnt_inc;
                    if (bit_cnt_inc == frame_bits) begin
                        data_n  = shreg_shift;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        gap_n   = 32'd1;
                        state_n = GAP;
                    end
                end
            end

            GAP: begin
                if (line_active) begin
                    len_n   = 32'd1;
                    state_n = PULSE;
                end else begin
                    gap_n = gap_inc;
                    if (gap_inc >= GAP_LIMIT) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            y0_q        <= 1'b0;
            nbits_q     <= 8'd0;
            n0_q        <= 32'd0;
            n1_q        <= 32'd0;
            len_q       <= 32'd0;
            bit_cnt_q   <= 9'd0;
            gap_q       <= 32'd0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            wait_idle_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            y0_q        <= y0_n;
            nbits_q     <= nbits_n;
            n0_q        <= n0_n;
            n1_q        <= n1_n;
            len_q       <= len_n;
            bit_cnt_q   <= bit_cnt_n;
            gap_q       <= gap_n;
            shreg_q     <= shreg_n;
            data_q      <= data_n;
            valid_q     <= valid_n;
            err_q       <= err_n;
            wait_idle_q <= wait_idle_n;
        end
    end

    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.err   = err_q;
    assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: directed tests for the pulse-width serial decoder.
// Inputs change on the falling edge, outputs are inspected on the falling
// edge, strobes are tallied on the rising edge.
module tb_serial_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks    = 0;
    int failures  = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;

    logic [255:0] exp_data;

    serial_rx_if bus_if();

    serial_rx #(.GAP_MAX(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Tally strobes as they are seen just before each rising edge.
    always @(posedge clk) begin
        if (bus_if.valid) valid_cnt <= valid_cnt + 1;
        if (bus_if.err)   err_cnt   <= err_cnt + 1;
        if (bus_if.valid && bus_if.err) both_cnt <= both_cnt + 1;
    end

    task automatic drive(input logic active);
        @(negedge clk);
        bus_if.y = active ? ~bus_if.y0 : bus_if.y0;
    endtask

    task automatic pulse(input int w);
        repeat (w) drive(1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0);
    endtask

    // Let the last driven sample be clocked in.
    task automatic sync_sample();
        @(negedge clk);
    endtask

    task automatic setup(input logic lvl, input logic [7:0] nb, input logic [31:0] w0, input logic [31:0] w1);
        @(negedge clk);
        bus_if.y0    = lvl;
        bus_if.y     = lvl;
        bus_if.nbits = nb;
        bus_if.n0    = w0;
        bus_if.n1    = w1;
    endtask

    // Sends nb bits MSB first; ends with the single end-of-frame idle drive.
    task automatic send_frame(input logic [255:0] word, input int nb, input int w0, input int w1, input int gap);
        for (int i = nb - 1; i >= 0; i--) begin
            pulse(word[i] ? w1 : w0);
            if (i > 0) idle(gap);
        end
        idle(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.y0 = 1'b1; bus_if.y = 1'b1;
        bus_if.nbits = 8'd16; bus_if.n0 = 32'd2; bus_if.n1 = 32'd3;
        repeat (3) @(negedge clk);
        checks++; if (bus_if.data !== 256'd0) begin failures++; $display("[TB] FAIL reset_data: got %h expected 0", bus_if.data); end
        checks++; if (bus_if.valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", bus_if.valid); end
        checks++; if (bus_if.err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", bus_if.err); end
        checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", bus_if.busy); end
        rst = 1'b0;
        exp_data = '0;
    endtask

    task automatic test_basic_frame();
        int vb, eb;
        setup(1'b1, 8'd16, 32'd2, 32'd3);
        vb = valid_cnt; eb = err_cnt;
        send_frame(256'h5aaa, 16, 2, 3, 1);
        sync_sample();
        exp_data = 256'h5aaa;
        checks++; if (bus_if.valid !== 1'b1) begin failures++; $display("[TB] FAIL basic_valid_edge: got %b expected 1", bus_if.valid); end
        checks++; if (bus_if.data !== exp_data) begin failures++; $display("[TB] FAIL basic_data: got %h expected %h", bus_if.data, exp_data); end
        sync_sample();
        checks++; if (bus_if.valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_valid_one_cycle: got %b expected 0", bus_if.valid); end
        checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_after: got %b expected 0", bus_if.busy); end
        idle(3);
        checks++; if (valid_cnt - vb !== 1) begin failures++; $display("[TB] FAIL basic_valid_count: got %0d expected 1", valid_cnt - vb); end
        checks++; if (err_cnt - eb !== 0) begin failures++; $display("[TB] FAIL basic_err_count: got %0d expected 0", err_cnt - eb); end
    endtask

    task automatic test_classify();
        int vb, eb;
        setup(1'b1, 8'd3, 32'd2, 32'd6);
        vb = valid_cnt; eb = err_cnt;
`ifdef SERIAL_RX_STRICT_WIDTH_EN
        pulse(4); idle(1);
        sync_sample();
        checks++; if (bus_if.err !== 1'b1) begin failures++; $display("[TB] FAIL strict_err_edge: got %b expected 1", bus_if.err); end
        idle(3);
        checks++; if (err_cnt - eb !== 1) begin failures++; $display("[TB] FAIL strict_err_count: got %0d expected 1", err_cnt - eb); end
        checks++; if (valid_cnt - vb !== 0) begin failures++; $display("[TB] FAIL strict_valid_count: got %0d expected 0", valid_cnt - vb); end
`else
        pulse(4); idle(1);
        pulse(5); idle(1);
        pulse(1); idle(1);
        sync_sample();
        exp_data = 256'd2;
        checks++; if (bus_if.data !== exp_data) begin failures++; $display("[TB] FAIL classify_data: got %h expected %h", bus_if.data, exp_data); end
        idle(3);
        checks++; if (valid_cnt - vb !== 1) begin failures++; $display("[TB] FAIL classify_valid_count: got %0d expected 1", valid_cnt - vb); end
        checks++; if (err_cnt - eb !== 0) begin failures++; $display("[TB] FAIL classify_err_count: got %0d expected 0", err_cnt - eb); end
`endif
    endtask

    task automatic test_gap();
        int vb, eb;
        // A gap of GAP_MAX-1 idle samples is still accepted.
        setup(1'b1, 8'd2, 32'd2, 32'd3);
        vb = valid_cnt; eb = err_cnt;
        pulse(2); idle(63); pulse(3); idle(1);
        sync_sample();
        exp_data = 256'd1;
        checks++; if (bus_if.valid !== 1'b1) begin failures++; $display("[TB] FAIL gap63_valid: got %b expected 1", bus_if.valid); end
        checks++; if (bus_if.data !== exp_data) begin failures++; $display("[TB] FAIL gap63_data: got %h expected %h", bus_if.data, exp_data); end
        idle(3);
        // GAP_MAX idle samples after pulse 3 abort the frame.
        setup(1'b1, 8'd8, 32'd2, 32'd3);
        vb = valid_cnt; eb = err_cnt;
        pulse(3); idle(1); pulse(2); idle(1); pulse(3);
        idle(63);
        sync_sample();
        checks++; if (bus_if.err !== 1'b0 || bus_if.busy !== 1'b1) begin failures++; $display("[TB] FAIL gap_before_limit: got err=%b busy=%b expected err=0 busy=1", bus_if.err, bus_if.busy); end
        sync_sample();
        checks++; if (bus_if.err !== 1'b1) begin failures++; $display("[TB] FAIL gap_err_edge: got %b expected 1", bus_if.err); end
        checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("[TB] FAIL gap_busy: got %b expected 0", bus_if.busy); end
        idle(3);
        checks++; if (err_cnt - eb !== 1 || valid_cnt - vb !== 0) begin failures++; $display("[TB] FAIL gap_counts: got err=%0d valid=%0d expected err=1 valid=0", err_cnt - eb, valid_cnt - vb); end
        checks++; if (bus_if.data !== exp_data) begin failures++; $display("[TB] FAIL gap_data_held: got %h expected %h", bus_if.data, exp_data); end
    endtask

    task automatic test_overlong();
        int vb, eb;
        setup(1'b1, 8'd8, 32'd2, 32'd3);
        vb = valid_cnt; eb = err_cnt;
        pulse(1);
        sync_sample();
        checks++; if (bus_if.busy !== 1'b1) begin failures++; $display("[TB] FAIL busy_rise: got %b expected 1", bus_if.busy); end
        pulse(4);
        sync_sample();
        checks++; if (bus_if.err !== 1'b0) begin failures++; $display("[TB] FAIL overlong_l6: got %b expected 0", bus_if.err); end
        sync_sample();
        checks++; if (bus_if.err !== 1'b1 || bus_if.busy !== 1'b0) begin failures++; $display("[TB] FAIL overlong_l7: got err=%b busy=%b expected err=1 busy=0", bus_if.err, bus_if.busy); end
        pulse(3);
        sync_sample();
        checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("[TB] FAIL overlong_no_restart: got %b expected 0", bus_if.busy); end
        idle(3);
        checks++; if (err_cnt - eb !== 1 || valid_cnt - vb !== 0) begin failures++; $display("[TB] FAIL overlong_counts: got err=%0d valid=%0d expected err=1 valid=0", err_cnt - eb, valid_cnt - vb); end
        checks++; if (bus_if.data !== exp_data) begin failures++; $display("[TB] FAIL overlong_data_held: got %h expected %h", bus_if.data, exp_data); end
    endtask

    task automatic test_reset_midframe();
        int vb, eb;
        setup(1'b1, 8'd16, 32'd2, 32'd3);
        vb = valid_cnt; eb = err_cnt;
        repeat (5) begin pulse(3); idle(1); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        checks++; if (bus_if.busy !== 1'b0 || bus_if.data !== 256'd0) begin failures++; $display("[TB] FAIL rst_mid: got busy=%b data=%h expected busy=0 data=0", bus_if.busy, bus_if.data); end
        rst = 1'b0;
        exp_data = '0;
        idle(3);
        checks++; if (err_cnt - eb !== 0 || valid_cnt - vb !== 0) begin failures++; $display("[TB] FAIL rst_mid_strobes: got err=%0d valid=%0d expected 0 0", err_cnt - eb, valid_cnt - vb); end
        send_frame(256'hbeef, 16, 2, 3, 1);
        sync_sample();
        exp_data = 256'hbeef;
        checks++; if (bus_if.data !== exp_data) begin failures++; $display("[TB] FAIL rst_next_frame: got %h expected %h", bus_if.data, exp_data); end
        idle(3);
        checks++; if (valid_cnt - vb !== 1) begin failures++; $display("[TB] FAIL rst_next_valid: got %0d expected 1", valid_cnt - vb); end
    endtask

    task automatic test_back_to_back();
        int vb, eb;
        setup(1'b0, 8'd4, 32'd2, 32'd3);
        vb = valid_cnt; eb = err_cnt;
        send_frame(256'ha, 4, 2, 3, 1);
        send_frame(256'h5, 4, 2, 3, 1);
        sync_sample();
        exp_data = 256'h5;
        checks++; if (bus_if.data !== exp_data) begin failures++; $display("[TB] FAIL b2b_data: got %h expected %h", bus_if.data, exp_data); end
        idle(3);
        checks++; if (valid_cnt - vb !== 2) begin failures++; $display("[TB] FAIL b2b_valid_count: got %0d expected 2", valid_cnt - vb); end
        checks++; if (err_cnt - eb !== 0) begin failures++; $display("[TB] FAIL b2b_err_count: got %0d expected 0", err_cnt - eb); end
    endtask

    task automatic test_wide_frame();
        int vb;
        logic [255:0] word;
        word = {128{2'b10}};
        setup(1'b0, 8'd0, 32'd1, 32'd2);
        vb = valid_cnt;
        send_frame(word, 256, 1, 2, 1);
        sync_sample();
        exp_data = word;
        checks++; if (bus_if.valid !== 1'b1) begin failures++; $display("[TB] FAIL wide_valid: got %b expected 1", bus_if.valid); end
        checks++; if (bus_if.data !== exp_data) begin failures++; $display("[TB] FAIL wide_data: got %h expected %h", bus_if.data, exp_data); end
        idle(3);
        checks++; if (valid_cnt - vb !== 1) begin failures++; $display("[TB] FAIL wide_valid_count: got %0d expected 1", valid_cnt - vb); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_classify();
        test_gap();
        test_overlong();
        test_reset_midframe();
        test_back_to_back();
        test_wide_frame();
        checks++; if (both_cnt !== 0) begin failures++; $display("[TB] FAIL valid_err_overlap: got %0d expected 0", both_cnt); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_rx.md
# serial_rx

Pulse-width serial decoder: the receive-side counterpart of `serial_tx`. Samples a single-wire line `y`, measures the width of each active pulse against the configured "0" and "1" widths `n0`/`n1`, and assembles `nbits` bits (first bit received = MSB) into a parallel word. It sits at the far end of a `serial_tx` link, in the same clock domain, and hands completed words to downstream logic with a one-cycle strobe.

## Interface
- `GAP_MAX`, default 64: idle clocks between pulses, within a frame, that abort the frame.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `y`  input  1  serial line; same clock domain, sampled directly.
- `y0`  input  1  idle line level; active level is `!y0`.
- `nbits`  input  8  bits per frame; 1..255; 0 means 256.
- `n0`  input  32  active-pulse width, in clocks, encoding a 0.
- `n1`  input  32  active-pulse width encoding a 1; `n0 != n1`, both ≥ 1.
- `data`  output  256  received word, right-justified, upper bits zero.
- `valid`  output  1  one-cycle strobe: `data` updated with a good frame.
- `err`  output  1  one-cycle strobe: frame aborted.
- `busy`  output  1  frame in progress.

## Operation
- Encoding:
  - Each bit is one active pulse of `n0` or `n1` clocks.
  - Each pulse is followed by at least 1 idle clock.
  - A frame is `nbits` pulses.
- Pulse width L is the number of consecutive rising edges at which `y != y0`.
- States:
  - IDLE:
    - On `y != y0`, latch `y0`, `nbits`, `n0`, `n1`; set L=1 and bit count=0; go to PULSE.
    - Mid-frame input changes are ignored.
  - PULSE:
    - While `y` is active, L increments (saturating at 2^32-1).
    - On the first idle sample, classify L, shift the bit into a 256-bit shift register (LSB in) and increment the bit count.
    - If the bit count equals `nbits`: load `data`, pulse `valid`, go to IDLE.
    - Otherwise clear the gap counter, set it to 1, and go to GAP.
  - GAP:
    - On an active sample, set L=1 and go to PULSE.
    - On an idle sample, increment the gap counter; if it reaches `GAP_MAX`, pulse `err` and go to IDLE.
- Classification (default): bit = 1 iff |L−n1| < |L−n0|, computed at 33-bit width; ties decode 0.
- Over-long pulse: if L exceeds 2·max(n0,n1) while in PULSE, pulse `err` and go to IDLE immediately. The line must return to idle before a new frame is detected.
- `data` holds its value until the next good frame; an aborted frame leaves `data` unchanged.
- `busy` = state != IDLE.

## Timing
- Reset values: `data`=0, `valid`=0, `err`=0, `busy`=0, state IDLE, all counters 0.
- `busy` rises the cycle after the first active sample.
- `valid`/`data` update at the edge that samples the first idle level after pulse `nbits`. `valid` is high for exactly that one following cycle.
- `valid` and `err` are never high together.
- Back-to-back frames: a new frame may begin on the sample immediately after the end-of-frame idle sample; `busy` may drop for one cycle.
- Reset mid-frame: return to IDLE next cycle, no `valid`, no `err`, `data` cleared.
- Minimum gap of 1 idle clock is accepted. A gap of `GAP_MAX` idle samples aborts the frame.

## Configuration
- `SERIAL_RX_STRICT_WIDTH_EN`:
  - Defined: L must equal exactly `n0` (decode 0) or `n1` (decode 1). Any other width pulses `err` at the end of that pulse and returns to IDLE.
  - Undefined: nearest-width classification as above; only the over-long and gap-timeout rules raise `err`.

## Test plan
- `nbits`=16, data 0x5aaa, `n0`=2, `n1`=3, `y0`=1, 1-clock gaps -> single `valid`, `data`=0x5aaa, `busy` low after.
- Non-strict, `n0`=2, `n1`=6, `nbits`=3, pulses of width 4, 5, 1 -> `data`=0b010 (tie→0, 5→1, 1→0); strict build -> `err` after first pulse.
- `nbits`=8, `GAP_MAX`=64, line idles 64 clocks after pulse 3 -> `err` one cycle, no `valid`, `data` unchanged.
- `n0`=2, `n1`=3, pulse held 7 clocks -> `err` at L=7; no new frame until the line returns to idle.
- `rst` asserted after pulse 5 of a 16-bit frame -> no strobes, `data`=0, next full frame decodes correctly.
- `nbits`=0, 256 alternating 1/0 bits -> `data`=0xAAAA…AAAA (256 bits), one `valid`.
